// File: rtl/obstacle_collision_ctrl.sv
// Player/obstacle collision detector and per-frame game FSM (lives, invulnerability, score).
// Optional build macro COLLISION_FLASH_EN enables the player blink output during invulnerability.
module obstacle_collision_ctrl #(
  parameter int N_OBST        = 3,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int SCORE_DIV     = 60,
  parameter int SCORE_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_v_sync,
  input  logic               i_de,
  input  logic               i_player_hit,
  input  logic [N_OBST-1:0]  i_obstacle_hit,
  input  logic               i_start,
  output logic [3:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_state,
  output logic               o_game_over,
  output logic               o_hit_pulse,
  output logic               o_flash
);

  localparam int CNT_RAW = $clog2(INVULN_FRAMES + 1);
  localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;
  localparam int PRE_W   = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               over_q;
  logic               vsync_d;
  logic               coll_flag, coll_d;
  logic               tick, coll_now, start_go;

  assign tick     = i_v_sync & ~vsync_d;
  assign coll_now = i_de & i_player_hit & (|i_obstacle_hit);
  assign start_go = ((state_q == IDLE) || (state_q == OVER)) & i_start;

  // A collision on the tick cycle seeds the next frame's flag; a restart clears it.
  always_comb begin
    coll_d = coll_flag | coll_now;
    if (start_go)  coll_d = 1'b0;
    else if (tick) coll_d = coll_now;
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (i_start) begin
          state_d = PLAY;
          lives_d = 4'(LIVES);
          score_d = '0;
          pre_d   = '0;
        end
      end
      PLAY, INVULN: begin
        if (tick) begin
          // Survival score advances on every live frame, including the one that costs a life.
          if (pre_q == PRE_W'(SCORE_DIV - 1)) begin
            pre_d   = '0;
            score_d = (score_q == '1) ? score_q : score_q + 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
          if (state_q == PLAY) begin
            if (coll_flag) begin
              hit_d   = 1'b1;
              lives_d = lives_q - 4'd1;
              if (lives_q == 4'd1) begin
                state_d = OVER;
              end else begin
                state_d = INVULN;
                cnt_d   = CNT_W'(INVULN_FRAMES);
              end
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = PLAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      lives_q   <= '0;
      score_q   <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      over_q    <= 1'b0;
      vsync_d   <= 1'b0;
      coll_flag <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      over_q    <= (state_d == OVER);
      vsync_d   <= i_v_sync;
      coll_flag <= coll_d;
    end
  end

`ifdef COLLISION_FLASH_EN
  // Bit 3 of the remaining-frame count gives an 8-frame on / 8-frame off blink.
  logic flash_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) flash_q <= 1'b0;
    else       flash_q <= (state_d == INVULN) & cnt_d[3];
  end
  assign o_flash = flash_q;
`else
  assign o_flash = 1'b0;
`endif

  assign o_state     = state_q;
  assign o_lives     = lives_q;
  assign o_score     = score_q;
  assign o_game_over = over_q;
  assign o_hit_pulse = hit_q;

endmodule
